// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer and its flush consumers.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_BUBBLE = 2'd1,
    ST_MEM_WAIT  = 2'd2,
    ST_HALTED    = 2'd3
  } pipe_state_e;

  localparam int unsigned INSTR_W = 32;
  // addi x0, x0, 0 -- loaded by IF/ID and ID/EX on flush
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  localparam stage_en_t EN_NONE = 5'b00000;
  localparam stage_en_t EN_ALL  = 5'b11111;

endpackage

// File: rtl/pipeline_stall_ctrl_perf_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module pipeline_stall_ctrl_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// 5-stage pipeline sequencer: stage enables/flushes from hazards, memory waits and halt.
// Optional perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] bubble_count
);

  localparam int unsigned TC_W = TO_W + 1;

  pipe_state_e     state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
  logic            lu_pend_q, lu_pend_d;

  stage_en_t       en_c;
  logic            if_id_flush_c;
  logic            id_ex_flush_c;
  logic            mem_stall_c;
  logic            lu_masked_c;
  logic [TC_W-1:0] wait_cnt_c;
  logic            stall_ev_c;
  logic            flush_ev_c;
  logic            bubble_ev_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      to_q      <= '0;
      err_q     <= 1'b0;
      lu_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      err_q     <= err_d;
      lu_pend_q <= lu_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    to_d          = to_q;
    err_d         = err_q;
    lu_pend_d     = lu_pend_q;
    en_c          = EN_NONE;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    flush_ev_c    = 1'b0;
    bubble_ev_c   = 1'b0;
    wait_cnt_c    = '0;
    // Once waiting, only dmem_ready releases the freeze.
    mem_stall_c   = (state_q == ST_MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);
    // A bubble already issued for this load-use must not be repeated, even across a freeze.
    lu_masked_c   = (state_q == ST_LU_BUBBLE) || ((state_q == ST_MEM_WAIT) && lu_pend_q);

    if (rst || (state_q == ST_HALTED)) begin
      // everything held off
    end else if (halt_req) begin
      state_d = ST_HALTED;
    end else if (mem_stall_c) begin
      wait_cnt_c = TC_W'(1) + ((state_q == ST_MEM_WAIT) ? TC_W'(to_q) : TC_W'(0));
      if (state_q != ST_MEM_WAIT) begin
        lu_pend_d = (state_q == ST_LU_BUBBLE);
      end
      if (wait_cnt_c >= TC_W'(MEM_TIMEOUT)) begin
        err_d   = 1'b1;
        state_d = ST_HALTED;
      end else begin
        to_d    = wait_cnt_c[TO_W-1:0];
        state_d = ST_MEM_WAIT;
      end
    end else begin
      en_c      = EN_ALL;
      lu_pend_d = 1'b0;
      state_d   = ST_RUN;
      if (branch_taken) begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        flush_ev_c    = 1'b1;
      end else if (load_use_stall && !lu_masked_c) begin
        en_c.pc       = 1'b0;
        en_c.if_id    = 1'b0;
        id_ex_flush_c = 1'b1;
        bubble_ev_c   = 1'b1;
        state_d       = ST_LU_BUBBLE;
      end else if (!imem_ready) begin
        en_c.pc       = 1'b0;
        if_id_flush_c = 1'b1;
      end
    end

    stall_ev_c = !rst && (state_q != ST_HALTED) && !en_c.pc;
  end

  assign pc_en           = en_c.pc;
  assign if_id_en        = en_c.if_id;
  assign id_ex_en        = en_c.id_ex;
  assign ex_mem_en       = en_c.ex_mem;
  assign mem_wb_en       = en_c.mem_wb;
  assign if_id_flush     = if_id_flush_c;
  assign id_ex_flush     = id_ex_flush_c;
  assign halted          = (state_q == ST_HALTED);
  assign mem_timeout_err = err_q;

`ifdef PIPE_PERF_CNT_EN
  pipeline_stall_ctrl_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(stall_ev_c), .count(stall_cycles)
  );
  pipeline_stall_ctrl_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(flush_ev_c), .count(flush_count)
  );
  pipeline_stall_ctrl_perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(bubble_ev_c), .count(bubble_count)
  );
`else
  logic unused_perf_ev;
  assign unused_perf_ev = ^{stall_ev_c, flush_ev_c, bubble_ev_c};
  assign stall_cycles   = '0;
  assign flush_count    = '0;
  assign bubble_count   = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vector table, corner sequences, random vs. reference model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned TW = 8;
  localparam int unsigned CW = 8;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  logic load_use_stall, branch_taken, imem_ready, dmem_req, dmem_ready, halt_req;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic halted, mem_timeout_err;
  logic [CW-1:0] stall_cycles, flush_count, bubble_count;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(TO), .TO_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .load_use_stall(load_use_stall), .branch_taken(branch_taken), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, halted, err}
  function automatic logic [8:0] outs();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
            halted, mem_timeout_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic lu, input logic br, input logic imr,
                       input logic dreq, input logic drdy, input logic hlt);
    load_use_stall = lu;
    branch_taken   = br;
    imem_ready     = imr;
    dmem_req       = dreq;
    dmem_ready     = drdy;
    halt_req       = hlt;
  endtask

  function automatic int perf_exp(input int v);
    int mx;
    mx = (1 << CW) - 1;
    if (!PERF) return 0;
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: tracks facts about history, not the controller's states.
  bit m_halted, m_err, m_mask;
  int m_wait;
  int c_stall, c_flush, c_bubble;
  bit n_halted, n_err, n_mask;
  int n_wait;
  int n_stall, n_flush, n_bubble;

  task automatic model_reset();
    m_halted = 0; m_err = 0; m_mask = 0; m_wait = 0;
    c_stall = 0; c_flush = 0; c_bubble = 0;
  endtask

  task automatic model_eval(output logic [8:0] exp);
    logic [6:0] o;
    bit frozen;
    o = 7'b0;
    n_halted = m_halted; n_err = m_err; n_mask = m_mask; n_wait = m_wait;
    n_stall = c_stall; n_flush = c_flush; n_bubble = c_bubble;
    if (m_halted) begin
      o = 7'b0;
    end else if (halt_req) begin
      n_halted = 1;
      n_stall++;
    end else begin
      frozen = (m_wait > 0) ? !dmem_ready : (dmem_req && !dmem_ready);
      if (frozen) begin
        n_stall++;
        n_wait = m_wait + 1;
        if (n_wait >= int'(TO)) begin
          n_err = 1;
          n_halted = 1;
        end
      end else begin
        n_wait = 0;
        n_mask = 0;
        o = 7'b1111100;
        if (branch_taken) begin
          o = 7'b1111111;
          n_flush++;
        end else if (load_use_stall && !m_mask) begin
          o = 7'b0011101;
          n_bubble++;
          n_mask = 1;
          n_stall++;
        end else if (!imem_ready) begin
          o = 7'b0111110;
          n_stall++;
        end
      end
    end
    exp = {o, m_halted, m_err};
  endtask

  task automatic model_commit();
    m_halted = n_halted; m_err = n_err; m_mask = n_mask; m_wait = n_wait;
    c_stall = n_stall; c_flush = n_flush; c_bubble = n_bubble;
  endtask

  // Called at a negedge with inputs driven; returns at the following negedge.
  task automatic run_cycle(input string name);
    logic [8:0] e;
    #1;
    model_eval(e);
    check(name, 32'(outs()), 32'(e));
    check({name, "_stall"}, 32'(stall_cycles), 32'(perf_exp(c_stall)));
    check({name, "_flush"}, 32'(flush_count), 32'(perf_exp(c_flush)));
    check({name, "_bubble"}, 32'(bubble_count), 32'(perf_exp(c_bubble)));
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 1, 0, 0, 0);
    #1;
    check("rst_outs", 32'(outs()), 32'd0);
    check("rst_cnt", 32'({stall_cycles, flush_count, bubble_count}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       lu, br, imr, dreq, drdy, hlt;
    logic [6:0] exp_o;
    logic       exp_h;
  } vec_t;

  function automatic vec_t mk(input logic lu, input logic br, input logic imr, input logic dreq,
                              input logic drdy, input logic hlt, input logic [6:0] eo,
                              input logic eh);
    vec_t v;
    v.lu = lu; v.br = br; v.imr = imr; v.dreq = dreq; v.drdy = drdy; v.hlt = hlt;
    v.exp_o = eo; v.exp_h = eh;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[20];
    tbl[0]  = mk(0, 0, 1, 0, 0, 0, 7'b1111100, 0);
    tbl[1]  = mk(1, 0, 1, 0, 0, 0, 7'b0011101, 0);
    tbl[2]  = mk(1, 0, 1, 0, 0, 0, 7'b1111100, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 0, 7'b1111100, 0);
    tbl[4]  = mk(1, 1, 1, 0, 0, 0, 7'b1111111, 0);
    tbl[5]  = mk(1, 0, 1, 0, 0, 0, 7'b0011101, 0);
    tbl[6]  = mk(1, 0, 1, 1, 0, 0, 7'b0000000, 0);
    tbl[7]  = mk(1, 0, 1, 1, 0, 0, 7'b0000000, 0);
    tbl[8]  = mk(1, 0, 1, 1, 1, 0, 7'b1111100, 0);
    tbl[9]  = mk(1, 0, 1, 0, 0, 0, 7'b0011101, 0);
    tbl[10] = mk(0, 0, 1, 0, 0, 0, 7'b1111100, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 7'b0111110, 0);
    tbl[12] = mk(0, 0, 1, 1, 0, 0, 7'b0000000, 0);
    tbl[13] = mk(0, 0, 1, 1, 0, 0, 7'b0000000, 0);
    tbl[14] = mk(0, 0, 1, 1, 0, 0, 7'b0000000, 0);
    tbl[15] = mk(0, 0, 1, 1, 1, 0, 7'b1111100, 0);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 7'b1111111, 0);
    tbl[17] = mk(0, 0, 1, 0, 0, 1, 7'b0000000, 0);
    tbl[18] = mk(0, 0, 1, 0, 0, 0, 7'b0000000, 1);
    tbl[19] = mk(1, 1, 1, 0, 0, 0, 7'b0000000, 1);

    rst = 1'b1;
    drive(0, 0, 1, 0, 0, 0);
    model_reset();
    @(negedge clk);
    do_reset();

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].lu, tbl[i].br, tbl[i].imr, tbl[i].dreq, tbl[i].drdy, tbl[i].hlt);
      #1;
      check($sformatf("vec%0d", i), 32'(outs()), 32'({tbl[i].exp_o, tbl[i].exp_h, 1'b0}));
      @(posedge clk);
      @(negedge clk);
    end
    check("tbl_stall", 32'(stall_cycles), 32'(perf_exp(10)));
    check("tbl_flush", 32'(flush_count), 32'(perf_exp(2)));
    check("tbl_bubble", 32'(bubble_count), 32'(perf_exp(3)));

    // Memory timeout: four frozen cycles then sticky error and halt
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, 0, 0);
      #1;
      check($sformatf("to_wait%0d", i), 32'(outs()), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 1, 0);
      #1;
      check($sformatf("to_sticky%0d", i), 32'(outs()), 32'(9'b0000000_11));
      @(posedge clk);
      @(negedge clk);
    end
    check("to_stall", 32'(stall_cycles), 32'(perf_exp(4)));

    // Halt, then asynchronous reset while halted
    do_reset();
    drive(0, 0, 1, 0, 0, 1);
    #1;
    check("halt_req_cycle", 32'(outs()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("halted%0d", i), 32'(outs()), 32'(9'b0000000_10));
      @(posedge clk);
      @(negedge clk);
    end
    #3 rst = 1'b1;
    #2 check("async_rst_halt", 32'(outs()), 32'd0);
    #1 rst = 1'b0;
    model_reset();
    run_cycle("post_halt_rst");

    // Asynchronous reset pulse mid MEM_WAIT, no clock edge while asserted
    drive(0, 0, 1, 1, 0, 0);
    run_cycle("mw_a");
    run_cycle("mw_b");
    #3 rst = 1'b1;
    #2 check("async_rst_mw", 32'(outs()), 32'd0);
    #1 rst = 1'b0;
    model_reset();
    drive(0, 0, 1, 0, 0, 0);
    run_cycle("post_mw_rst");

    // Three-cycle data wait from clean counters
    do_reset();
    drive(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) run_cycle("dwait");
    drive(0, 0, 1, 1, 1, 0);
    run_cycle("dwait_rdy");
    check("dwait_stall", 32'(stall_cycles), 32'(perf_exp(3)));

    // Counter saturation on a long fetch stall
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) run_cycle("imem_long");
    check("stall_sat", 32'(stall_cycles), 32'(perf_exp(300)));

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (m_halted && ($urandom_range(9) == 0)) begin
        do_reset();
      end else begin
        drive($urandom_range(99) < 25, $urandom_range(99) < 10, $urandom_range(99) < 85,
              $urandom_range(99) < 30, $urandom_range(99) < 70, $urandom_range(199) == 0);
        run_cycle("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
